// File: rtl/systolic_mac_pe.sv
// Systolic MAC processing element: forwards A (with slot/first/last tags) right and B down,
// accumulates A*B into one of ACC_DEPTH slots and offers finished sums through a 1-entry result register.
module systolic_mac_pe #(
   parameter int unsigned DW        = 16,
   parameter int unsigned AW        = 40,
   parameter int unsigned ACC_DEPTH = 4,
   parameter int unsigned SAT       = 0,
   parameter int unsigned SW        = $clog2(ACC_DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          signed_mode,
   input  logic [DW-1:0] a_in,
   input  logic          a_vld_in,
   input  logic [SW-1:0] slot_in,
   input  logic          first_in,
   input  logic          last_in,
   output logic [DW-1:0] a_out,
   output logic          a_vld_out,
   output logic [SW-1:0] slot_out,
   output logic          first_out,
   output logic          last_out,
   input  logic [DW-1:0] b_in,
   input  logic          b_vld_in,
   output logic [DW-1:0] b_out,
   output logic          b_vld_out,
   output logic [AW-1:0] res_data,
   output logic [SW-1:0] res_slot,
   output logic          res_valid,
   input  logic          res_ready,
   input  logic          err_clr,
   output logic          ovf_err
);

   localparam int unsigned PW = 2 * DW;

   logic [DW-1:0]        a_q, a_d, b_q, b_d;
   logic                 a_vld_q, a_vld_d, b_vld_q, b_vld_d;
   logic [SW-1:0]        slot_q, slot_d;
   logic                 first_q, first_d, last_q, last_d;
   logic [AW-1:0]        acc_q [ACC_DEPTH];
   logic [AW-1:0]        acc_d [ACC_DEPTH];
   logic [AW-1:0]        res_data_q, res_data_d;
   logic [SW-1:0]        res_slot_q, res_slot_d;
   logic                 res_valid_q, res_valid_d;
   logic                 ovf_q, ovf_d;

   logic                 mac_c;
   logic signed [PW-1:0] prod_s_c;
   logic [PW-1:0]        prod_u_c;
   logic [AW-1:0]        prod_x_c;
   logic [AW-1:0]        acc_cur_c;
   logic [AW:0]          sum_c;
   logic                 sum_ovf_c;
   logic [AW-1:0]        clamp_c;
   logic [AW-1:0]        new_c;
   logic                 offer_c, load_c, drop_c;

   // Datapath: product extended to AW, one extra sum bit exposes overflow for saturation
   always_comb begin
      mac_c     = a_vld_in & b_vld_in;
      prod_s_c  = PW'($signed(a_in)) * PW'($signed(b_in));
      prod_u_c  = PW'(a_in) * PW'(b_in);
      prod_x_c  = signed_mode ? AW'(prod_s_c) : AW'(prod_u_c);
      acc_cur_c = acc_q[slot_in];
      sum_c     = {signed_mode & acc_cur_c[AW-1], acc_cur_c}
                + {signed_mode & prod_x_c[AW-1], prod_x_c};
      sum_ovf_c = signed_mode ? (sum_c[AW] ^ sum_c[AW-1]) : sum_c[AW];
      if (!signed_mode)
         clamp_c = {AW{1'b1}};
      else if (sum_c[AW])
         clamp_c = {1'b1, {(AW-1){1'b0}}};
      else
         clamp_c = {1'b0, {(AW-1){1'b1}}};
      if (first_in)
         new_c = prod_x_c;
      else if ((SAT != 0) && sum_ovf_c)
         new_c = clamp_c;
      else
         new_c = sum_c[AW-1:0];
      offer_c = mac_c & last_in;
      load_c  = offer_c & (~res_valid_q | res_ready);
      drop_c  = offer_c & res_valid_q & ~res_ready;
   end

   always_comb begin
      a_vld_d     = a_vld_in;
      a_d         = a_q;
      slot_d      = slot_q;
      first_d     = first_q;
      last_d      = last_q;
      b_vld_d     = b_vld_in;
      b_d         = b_q;
      acc_d       = acc_q;
      res_data_d  = res_data_q;
      res_slot_d  = res_slot_q;
      res_valid_d = res_valid_q;
      ovf_d       = ovf_q;

      if (a_vld_in) begin
         a_d     = a_in;
         slot_d  = slot_in;
         first_d = first_in;
         last_d  = last_in;
      end
      if (b_vld_in)
         b_d = b_in;
      if (mac_c)
         acc_d[slot_in] = new_c;

      // A new load wins over draining; a full, stalled register drops the new sum
      if (load_c) begin
         res_data_d  = new_c;
         res_slot_d  = slot_in;
         res_valid_d = 1'b1;
      end else if (res_valid_q && res_ready) begin
         res_valid_d = 1'b0;
      end

      if (drop_c)
         ovf_d = 1'b1;
      else if (err_clr)
         ovf_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q         <= '0;
         a_vld_q     <= 1'b0;
         slot_q      <= '0;
         first_q     <= 1'b0;
         last_q      <= 1'b0;
         b_q         <= '0;
         b_vld_q     <= 1'b0;
         for (int i = 0; i < int'(ACC_DEPTH); i++)
            acc_q[i] <= '0;
         res_data_q  <= '0;
         res_slot_q  <= '0;
         res_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         a_q         <= a_d;
         a_vld_q     <= a_vld_d;
         slot_q      <= slot_d;
         first_q     <= first_d;
         last_q      <= last_d;
         b_q         <= b_d;
         b_vld_q     <= b_vld_d;
         acc_q       <= acc_d;
         res_data_q  <= res_data_d;
         res_slot_q  <= res_slot_d;
         res_valid_q <= res_valid_d;
         ovf_q       <= ovf_d;
      end
   end

   assign a_out     = a_q;
   assign a_vld_out = a_vld_q;
   assign slot_out  = slot_q;
   assign first_out = first_q;
   assign last_out  = last_q;
   assign b_out     = b_q;
   assign b_vld_out = b_vld_q;
   assign res_data  = res_data_q;
   assign res_slot  = res_slot_q;
   assign res_valid = res_valid_q;
   assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Directed bench for systolic_mac_pe: default 40-bit wrap instance scored through a result queue,
// plus 32-bit saturating and wrapping instances for accumulator overflow behaviour.
module tb_systolic_mac_pe;

   localparam int unsigned DW  = 16;
   localparam int unsigned AW  = 40;
   localparam int unsigned AW2 = 32;
   localparam int unsigned SW  = 2;

   typedef struct packed {
      logic [AW-1:0] data;
      logic [SW-1:0] slot;
   } res_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          signed_mode = 1'b1;
   logic [DW-1:0] a_in = '0, b_in = '0;
   logic          a_vld_in = 1'b0, b_vld_in = 1'b0;
   logic [SW-1:0] slot_in = '0;
   logic          first_in = 1'b0, last_in = 1'b0;
   logic          res_ready = 1'b1, err_clr = 1'b0;

   logic [DW-1:0] a_out, b_out;
   logic          a_vld_out, b_vld_out, first_out, last_out, res_valid, ovf_err;
   logic [SW-1:0] slot_out, res_slot;
   logic [AW-1:0] res_data;

   logic [DW-1:0]  s_a_out, s_b_out, w_a_out, w_b_out;
   logic           s_a_vld, s_b_vld, s_first, s_last, s_res_valid, s_ovf;
   logic           w_a_vld, w_b_vld, w_first, w_last, w_res_valid, w_ovf;
   logic [SW-1:0]  s_slot_out, s_res_slot, w_slot_out, w_res_slot;
   logic [AW2-1:0] s_res_data, w_res_data;

   int   n_assert = 0;
   int   n_fail   = 0;
   res_t exp_q[$];

   always #5 clk = ~clk;

   systolic_mac_pe u_dut (
      .clk(clk), .rst(rst), .signed_mode(signed_mode),
      .a_in(a_in), .a_vld_in(a_vld_in), .slot_in(slot_in), .first_in(first_in), .last_in(last_in),
      .a_out(a_out), .a_vld_out(a_vld_out), .slot_out(slot_out), .first_out(first_out), .last_out(last_out),
      .b_in(b_in), .b_vld_in(b_vld_in), .b_out(b_out), .b_vld_out(b_vld_out),
      .res_data(res_data), .res_slot(res_slot), .res_valid(res_valid), .res_ready(res_ready),
      .err_clr(err_clr), .ovf_err(ovf_err)
   );

   systolic_mac_pe #(.AW(AW2), .SAT(1)) u_sat (
      .clk(clk), .rst(rst), .signed_mode(signed_mode),
      .a_in(a_in), .a_vld_in(a_vld_in), .slot_in(slot_in), .first_in(first_in), .last_in(last_in),
      .a_out(s_a_out), .a_vld_out(s_a_vld), .slot_out(s_slot_out), .first_out(s_first), .last_out(s_last),
      .b_in(b_in), .b_vld_in(b_vld_in), .b_out(s_b_out), .b_vld_out(s_b_vld),
      .res_data(s_res_data), .res_slot(s_res_slot), .res_valid(s_res_valid), .res_ready(res_ready),
      .err_clr(err_clr), .ovf_err(s_ovf)
   );

   systolic_mac_pe #(.AW(AW2), .SAT(0)) u_wrap (
      .clk(clk), .rst(rst), .signed_mode(signed_mode),
      .a_in(a_in), .a_vld_in(a_vld_in), .slot_in(slot_in), .first_in(first_in), .last_in(last_in),
      .a_out(w_a_out), .a_vld_out(w_a_vld), .slot_out(w_slot_out), .first_out(w_first), .last_out(w_last),
      .b_in(b_in), .b_vld_in(b_vld_in), .b_out(w_b_out), .b_vld_out(w_b_vld),
      .res_data(w_res_data), .res_slot(w_res_slot), .res_valid(w_res_valid), .res_ready(res_ready),
      .err_clr(err_clr), .ovf_err(w_ovf)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Score any handshake about to happen, then advance one cycle and settle past the edge
   task automatic step();
      res_t e;
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 64'(res_data), 64'hDEAD);
         end else begin
            e = exp_q.pop_front();
            check("res_data", 64'(res_data), 64'(e.data));
            check("res_slot", 64'(res_slot), 64'(e.slot));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [DW-1:0] a, input logic av, input logic [DW-1:0] b, input logic bv,
                        input logic [SW-1:0] s, input logic f, input logic l);
      a_in = a; a_vld_in = av; b_in = b; b_vld_in = bv;
      slot_in = s; first_in = f; last_in = l;
   endtask

   task automatic term(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [SW-1:0] s, input logic f, input logic l);
      drive(a, 1'b1, b, 1'b1, s, f, l);
      step();
   endtask

   task automatic idle();
      drive('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      step();
   endtask

   task automatic push(input logic [AW-1:0] d, input logic [SW-1:0] s);
      res_t e;
      e.data = d;
      e.slot = s;
      exp_q.push_back(e);
   endtask

   initial begin
      // Reset state
      #1;
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_a_vld_out", 64'(a_vld_out), 64'd0);
      check("rst_ovf_err",   64'(ovf_err),   64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;

      // Signed three-term dot product on slot 0: 12 - 10 - 7 = -5
      signed_mode = 1'b1;
      term(16'd3, 16'd4, 2'd0, 1'b1, 1'b0);
      check("fwd_a_out_t1",  64'(a_out),     64'd3);
      check("fwd_b_out_t1",  64'(b_out),     64'd4);
      check("fwd_first_t1",  64'(first_out), 64'd1);
      term(16'hFFFE, 16'd5, 2'd0, 1'b0, 1'b0);
      check("no_res_before_last", 64'(res_valid), 64'd0);
      push(40'hFF_FFFF_FFFB, 2'd0);
      term(16'd7, 16'hFFFF, 2'd0, 1'b0, 1'b1);
      check("res_valid_after_last", 64'(res_valid), 64'd1);
      check("fwd_a_out_t3",  64'(a_out),    64'd7);
      check("fwd_b_out_t3",  64'(b_out),    64'hFFFF);
      check("fwd_last_t3",   64'(last_out), 64'd1);
      idle();
      check("drained_valid", 64'(res_valid), 64'd0);
      check("a_vld_out_idle", 64'(a_vld_out), 64'd0);
      check("a_out_holds",   64'(a_out),     64'd7);

      // Unsigned single term
      signed_mode = 1'b0;
      push(40'h00_FFFE_0001, 2'd0);
      term(16'hFFFF, 16'hFFFF, 2'd0, 1'b1, 1'b1);
      idle();

      // Interleaved slots 1 and 2 every cycle
      signed_mode = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) push(40'd4, 2'd1);
         term(16'd1, 16'd1, 2'd1, i == 0, i == 3);
         if (i == 3) push(40'd24, 2'd2);
         term(16'd2, 16'd3, 2'd2, i == 0, i == 3);
      end
      idle();
      idle();

      // A-only tags are forwarded but do not touch slot 1; B-only just forwards
      drive(16'd9, 1'b1, 16'd0, 1'b0, 2'd1, 1'b1, 1'b1);
      step();
      check("a_only_no_result", 64'(res_valid), 64'd0);
      check("a_only_first_fwd", 64'(first_out), 64'd1);
      drive(16'd0, 1'b0, 16'd7, 1'b1, 2'd0, 1'b0, 1'b0);
      step();
      check("b_only_b_out", 64'(b_out), 64'd7);
      check("b_only_a_out_hold", 64'(a_out), 64'd9);
      push(40'd29, 2'd1);
      term(16'd5, 16'd5, 2'd1, 1'b0, 1'b1);
      idle();

      // 3 * 0x3FFF0001 overflows 32-bit signed: clamp vs wrap
      push(40'h00_BFFD_0003, 2'd3);
      term(16'h7FFF, 16'h7FFF, 2'd3, 1'b1, 1'b0);
      term(16'h7FFF, 16'h7FFF, 2'd3, 1'b0, 1'b0);
      term(16'h7FFF, 16'h7FFF, 2'd3, 1'b0, 1'b1);
      check("sat_clamp",  64'(s_res_data), 64'h7FFF_FFFF);
      check("wrap_value", 64'(w_res_data), 64'hBFFD_0003);
      idle();

      // Back-pressure: second result dropped, sticky error, clear, set-beats-clear
      res_ready = 1'b0;
      push(40'd2, 2'd0);
      term(16'd1, 16'd2, 2'd0, 1'b1, 1'b1);
      term(16'd3, 16'd3, 2'd1, 1'b1, 1'b1);
      check("drop_ovf_set",  64'(ovf_err),   64'd1);
      check("drop_held_slot", 64'(res_slot), 64'd0);
      check("drop_held_data", 64'(res_data), 64'd2);
      err_clr = 1'b1;
      idle();
      check("err_clr", 64'(ovf_err), 64'd0);
      term(16'd4, 16'd4, 2'd2, 1'b1, 1'b1);
      check("set_beats_clr", 64'(ovf_err), 64'd1);
      err_clr = 1'b0;
      res_ready = 1'b1;
      idle();
      check("held_drained", 64'(res_valid), 64'd0);
      push(40'd10, 2'd1);
      term(16'd1, 16'd1, 2'd1, 1'b0, 1'b1);
      idle();

      // Asynchronous reset with a partial sum and a pending result
      term(16'd6, 16'd6, 2'd0, 1'b1, 1'b0);
      res_ready = 1'b0;
      term(16'd1, 16'd1, 2'd2, 1'b1, 1'b1);
      idle();
      #2;
      rst = 1'b0;
      #1;
      check("arst_res_valid", 64'(res_valid), 64'd0);
      check("arst_res_data",  64'(res_data),  64'd0);
      check("arst_ovf_err",   64'(ovf_err),   64'd0);
      check("arst_a_vld_out", 64'(a_vld_out), 64'd0);
      check("arst_b_out",     64'(b_out),     64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      res_ready = 1'b1;
      push(40'd42, 2'd0);
      term(16'd6, 16'd7, 2'd0, 1'b1, 1'b1);
      push(40'd1, 2'd2);
      term(16'd1, 16'd1, 2'd2, 1'b0, 1'b1);
      idle();
      idle();
      idle();

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
